// File: rtl/div_operand_issue_pkg.sv
// Shared widths and constants for the divider operand issue block.
// The divide-by-zero quotient is the all-ones pattern that the block itself substitutes.
package div_pkg;

    localparam int DIV_WIDTH      = 4;
    localparam int DIV_FIFO_DEPTH = 4;

    localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/div_operand_issue_if.sv
// Operand request and result handshakes between a producer/consumer and div_operand_issue.
// The slave modport is the issue block's view; the master modport is the environment's view.
interface div_operand_issue_if #(
    parameter int WIDTH = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             out_div_by_zero;

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero
    );

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero
    );

endinterface

// File: rtl/div_operand_issue_fifo.sv
// Synchronous operand-pair FIFO with occupancy count; pointers wrap modulo DEPTH.
// Pushes while full and pops while empty are ignored, so callers may drive them freely.
module div_op_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/div_operand_issue.sv
// Feeds buffered dividend/divisor pairs to a combinational divider and registers its results.
// Divide-by-zero is resolved here, so divider outputs for a zero divisor never reach the consumer.
module div_operand_issue
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DEPTH = DIV_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    div_operand_issue_if.slave     bus,
    output logic [WIDTH-1:0]       div_dividend,
    output logic [WIDTH-1:0]       div_divisor,
    input  logic [WIDTH-1:0]       div_quotient,
    input  logic [WIDTH-1:0]       div_remainder,
    output logic [$clog2(DEPTH):0] fifo_count
);

    logic [2*WIDTH-1:0] head_pair;
    logic               fifo_full;
    logic               fifo_empty;
    logic               issue_valid;
    logic               adv_out;
    logic               adv_issue;

    logic               out_valid;
    logic [WIDTH-1:0]   out_quotient;
    logic [WIDTH-1:0]   out_remainder;
    logic               out_div_by_zero;

    assign bus.in_ready        = !fifo_full;
    assign bus.out_valid       = out_valid;
    assign bus.out_quotient    = out_quotient;
    assign bus.out_remainder   = out_remainder;
    assign bus.out_div_by_zero = out_div_by_zero;

    // Each stage advances only when the stage downstream of it is empty or draining.
    assign adv_out   = issue_valid && (!out_valid || bus.out_ready);
    assign adv_issue = !fifo_empty && (!issue_valid || adv_out);

    div_op_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.in_valid),
        .push_data ({bus.in_dividend, bus.in_divisor}),
        .pop       (adv_issue),
        .pop_data  (head_pair),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid  <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else if (adv_issue) begin
            issue_valid  <= 1'b1;
            div_dividend <= head_pair[2*WIDTH-1:WIDTH];
            div_divisor  <= head_pair[WIDTH-1:0];
        end else if (adv_out) begin
            issue_valid  <= 1'b0;
        end
    end

    // A zero divisor bypasses the divider's (undefined) outputs with a fixed result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_quotient    <= '0;
            out_remainder   <= '0;
            out_div_by_zero <= 1'b0;
        end else if (adv_out) begin
            out_valid <= 1'b1;
            if (div_divisor == '0) begin
                out_quotient    <= DIV_DZ_QUOTIENT;
                out_remainder   <= div_dividend;
                out_div_by_zero <= 1'b1;
            end else begin
                out_quotient    <= div_quotient;
                out_remainder   <= div_remainder;
                out_div_by_zero <= 1'b0;
            end
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
